mat_stream_sequencer: RTL and testbench

- Upstream feeder for the matrix-multiply accelerator. Sits between the DMA MM2S stream and the accelerator's AXI-Stream slave.
- Accepts one combined stream per job: matrix A (SIZE words) followed by matrix B (SIZE words).
- Splits the stream into two per-matrix bursts, each terminated by tlast. Drives the matrix-select and start pulse itself, so software does not toggle them through AXI-Lite.
- Snoops the accelerator's result stream to detect job completion. Holds off the next job until the current one completes.

---
 rtl/mat_stream_pkg.sv | 27 ++
 rtl/mat_stream_sequencer_skid_buffer.sv | 67 ++++++
 rtl/mat_stream_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_mat_stream_sequencer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mat_stream_pkg.sv
// Shared types for the matrix-stream sequencer: FSM state encoding,
// skid-buffer entry tags and a small helper for input acceptance.
package mat_stream_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOAD_A     = 3'd1,
        LOAD_B     = 3'd2,
        START_WAIT = 3'd3,
        COMPUTE    = 3'd4,
        DRAIN      = 3'd5
    } state_t;

    // Sideband carried with every buffered word. The data field is added by
    // the top level because its width is a module parameter.
    typedef struct packed {
        logic sel_tag;
        logic last_tag;
    } entry_tag_t;

    // States in which the upstream stream may be accepted in the next cycle.
    function automatic logic accepts_input(input state_t st, input logic enable);
        return (st == LOAD_A) || (st == LOAD_B) || (st == DRAIN) ||
               ((st == IDLE) && enable);
    endfunction

endpackage

// File: rtl/mat_stream_sequencer_skid_buffer.sv
// Two-entry FIFO used as the skid buffer between the DMA stream and the
// accelerator. Pointers and occupancy are reset; the storage is not, since a
// stale entry is never visible while the buffer reports empty.
module axis_skid_buffer #(
    parameter int WIDTH = 34
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem_q [2];
    logic [WIDTH-1:0] mem_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             do_push, do_pop;

    // Guard against writes when full and reads when empty.
    assign do_push = push && (count_q != 2'd2);
    assign do_pop  = pop  && (count_q != 2'd0);

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d[0] = mem_q[0];
        mem_d[1] = mem_q[1];
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end

    // Control state: reset drops any buffered entries immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage, no reset needed.
    always_ff @(posedge clk) begin
        mem_q[0] <= mem_d[0];
        mem_q[1] <= mem_d[1];
    end

    assign head_data = mem_q[rd_ptr_q];
    assign empty     = (count_q == 2'd0);
    assign count     = count_q;

endmodule

// File: rtl/mat_stream_sequencer.sv
// Upstream feeder for the matrix-multiply accelerator. Splits one combined
// A|B job stream into two tlast-terminated bursts, tags each word with the
// matrix select, fires the start pulse once B has been delivered and waits
// for the result stream's tlast before admitting the next job.
module mat_stream_sequencer
    import mat_stream_pkg::*;
#(
    parameter int DIM_LOG    = 1,
    parameter int DIM        = 2 ** DIM_LOG,
    parameter int SIZE       = DIM * DIM,
    parameter int SIZE_LOG   = 2 * DIM_LOG,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  s00_axi_aclk,
    input  logic                  s00_axi_aresetn,
    input  logic [DATA_WIDTH-1:0] s00_axis_tdata,
    input  logic                  s00_axis_tvalid,
    input  logic                  s00_axis_tlast,
    output logic                  s00_axis_tready,
    output logic [DATA_WIDTH-1:0] m00_axis_tdata,
    output logic                  m00_axis_tvalid,
    output logic                  m00_axis_tlast,
    input  logic                  m00_axis_tready,
    output logic                  sel,
    output logic                  start,
    input  logic                  mon_tvalid,
    input  logic                  mon_tready,
    input  logic                  mon_tlast,
    input  logic                  enable,
    input  logic                  err_clr,
    output logic                  busy,
    output logic                  err_len,
    output logic [15:0]           job_count
);

    localparam int CNT_W = SIZE_LOG + 1;
    localparam logic [CNT_W-1:0] LAST_A = CNT_W'(SIZE - 1);
    localparam logic [CNT_W-1:0] LAST_B = CNT_W'(2 * SIZE - 1);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        entry_tag_t            tag;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
    logic             ready_q, ready_d;
    logic             start_q, start_d;
    logic             err_len_q, err_len_d;
    logic             drain_pend_q, drain_pend_d;
    logic             abort_q, abort_d;
    logic [15:0]      job_count_q, job_count_d;
    logic             sel_q, sel_d;

    logic               in_hs, word_hs, job_end, early_last, missing_last, err_set;
    logic               push, pop, m_valid, mon_hs, buf_empty;
    logic [1:0]         buf_count, buf_count_nxt;
    entry_t             push_entry, head;
    logic [ENTRY_W-1:0] head_raw;

    assign in_hs   = s00_axis_tvalid && ready_q;
    // Words accepted while loading are forwarded; words accepted in DRAIN are dropped.
    assign word_hs = in_hs && (state_q inside {IDLE, LOAD_A, LOAD_B});
    assign job_end = (in_cnt_q == LAST_B);
    // Early tlast: tlast before the final word of B. Missing tlast: final word without it.
    assign early_last   = s00_axis_tlast && !job_end;
    assign missing_last = job_end && !s00_axis_tlast;
    assign err_set      = word_hs && (early_last || missing_last);
    assign mon_hs       = mon_tvalid && mon_tready && mon_tlast;

    // Tag the incoming word with its matrix and burst-terminating flag.
    always_comb begin
        push_entry.data         = s00_axis_tdata;
        push_entry.tag.sel_tag  = (in_cnt_q > LAST_A);
        push_entry.tag.last_tag = (in_cnt_q == LAST_A) || job_end || s00_axis_tlast;
    end

    assign push = word_hs;
    assign pop  = m_valid && m00_axis_tready;

    axis_skid_buffer #(
        .WIDTH (ENTRY_W)
    ) u_skid (
        .clk       (s00_axi_aclk),
        .rst_n     (s00_axi_aresetn),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head_data (head_raw),
        .empty     (buf_empty),
        .count     (buf_count)
    );

    assign head          = entry_t'(head_raw);
    assign buf_count_nxt = buf_count + {1'b0, push} - {1'b0, pop};

    // Job FSM: in_cnt tracks the input position, START_WAIT waits for the
    // buffer to empty, COMPUTE waits for the result tlast.
    always_comb begin
        state_d      = state_q;
        in_cnt_d     = in_cnt_q;
        abort_d      = abort_q;
        drain_pend_d = drain_pend_q;
        job_count_d  = job_count_q;
        start_d      = 1'b0;
        unique case (state_q)
            IDLE, LOAD_A, LOAD_B: begin
                if (word_hs) begin
                    if (job_end || s00_axis_tlast) begin
                        // Input side of the job is finished; no more words until done.
                        state_d  = START_WAIT;
                        in_cnt_d = '0;
                        abort_d  = early_last;
                        if (missing_last) begin
                            drain_pend_d = 1'b1;
                        end
                    end else begin
                        in_cnt_d = in_cnt_q + CNT_W'(1);
                        state_d  = (in_cnt_q >= LAST_A) ? LOAD_B : LOAD_A;
                    end
                end
            end
            START_WAIT: begin
                // Nothing is pushed here, so popping the sole entry delivers the final word.
                if (pop && (buf_count == 2'd1)) begin
                    if (abort_q) begin
                        state_d = IDLE;
                        abort_d = 1'b0;
                    end else begin
                        start_d = 1'b1;
                        state_d = COMPUTE;
                    end
                end
            end
            COMPUTE: begin
                if (mon_hs) begin
                    job_count_d = job_count_q + 16'd1;
                    state_d     = drain_pend_q ? DRAIN : IDLE;
                end
            end
            DRAIN: begin
                if (in_hs && s00_axis_tlast) begin
                    state_d      = IDLE;
                    drain_pend_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered upstream ready: only offered when a slot is guaranteed next cycle.
    always_comb begin
        ready_d = (buf_count_nxt != 2'd2) && accepts_input(state_d, enable);
    end

    // Sticky length error; a new error outranks a simultaneous clear.
    always_comb begin
        if (err_set) begin
            err_len_d = 1'b1;
        end else if (err_clr) begin
            err_len_d = 1'b0;
        end else begin
            err_len_d = err_len_q;
        end
    end

    // Matrix select follows the head entry and holds while the buffer is empty.
    always_comb begin
        sel_d = buf_empty ? sel_q : head.tag.sel_tag;
    end

    // Control registers; reset aborts any job in flight.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            state_q      <= IDLE;
            in_cnt_q     <= '0;
            ready_q      <= 1'b0;
            start_q      <= 1'b0;
            err_len_q    <= 1'b0;
            drain_pend_q <= 1'b0;
            abort_q      <= 1'b0;
            job_count_q  <= 16'd0;
            sel_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_cnt_q     <= in_cnt_d;
            ready_q      <= ready_d;
            start_q      <= start_d;
            err_len_q    <= err_len_d;
            drain_pend_q <= drain_pend_d;
            abort_q      <= abort_d;
            job_count_q  <= job_count_d;
            sel_q        <= sel_d;
        end
    end

    assign m_valid         = !buf_empty && (state_q != DRAIN);
    assign m00_axis_tvalid = m_valid;
    assign m00_axis_tdata  = m_valid ? head.data : '0;
    assign m00_axis_tlast  = m_valid && head.tag.last_tag;
    assign sel             = sel_d;
    assign s00_axis_tready = ready_q;
    assign start           = start_q;
    assign busy            = (state_q != IDLE);
    assign err_len         = err_len_q;
    assign job_count       = job_count_q;

endmodule

// File: tb/tb_mat_stream_sequencer.sv
// Directed bench for mat_stream_sequencer (DIM_LOG = 1, four words per matrix).
module tb_mat_stream_sequencer;

    localparam int SIZE = 4;
    localparam int DW   = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] s_tdata;
    logic          s_tvalid, s_tlast, s_tready;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid, m_tlast, m_tready;
    logic          sel, start, busy, err_len;
    logic          mon_tvalid, mon_tready, mon_tlast;
    logic          enable, err_clr;
    logic [15:0]   job_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mat_stream_sequencer #(.DIM_LOG(1), .DATA_WIDTH(DW)) dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (rst_n),
        .s00_axis_tdata  (s_tdata),
        .s00_axis_tvalid (s_tvalid),
        .s00_axis_tlast  (s_tlast),
        .s00_axis_tready (s_tready),
        .m00_axis_tdata  (m_tdata),
        .m00_axis_tvalid (m_tvalid),
        .m00_axis_tlast  (m_tlast),
        .m00_axis_tready (m_tready),
        .sel             (sel),
        .start           (start),
        .mon_tvalid      (mon_tvalid),
        .mon_tready      (mon_tready),
        .mon_tlast       (mon_tlast),
        .enable          (enable),
        .err_clr         (err_clr),
        .busy            (busy),
        .err_len         (err_len),
        .job_count       (job_count)
    );

    // One job: words in, tlast position (1-based, 0 = none), output-ready
    // pattern, upstream gaps, and the expected outcome.
    typedef struct {
        int nw;
        int tl;
        int rdy_mode;
        int gap;
        int exp_fwd;
        int exp_start;
        int exp_jc;
        int exp_err;
    } job_t;

    job_t jobs[7];

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic rdy_pat(input int c);
        case (c % 6)
            0: return 1'b1;
            1: return 1'b0;
            2: return 1'b0;
            3: return 1'b1;
            4: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    // Entered and left at posedge + 1. Plays DMA source, accelerator sink and
    // result stream, then compares the job outcome with the table row.
    task automatic run_job(input int j, input int start_idx);
        job_t r;
        int   idx, cyc, occ, full_viol, comp_viol, start_cnt, cyc_start, cyc_last_out;
        int   mon_wait, bad_seq, n;
        bit   accepted, mon_pending, in_compute, done;
        int   got_d[$];
        bit   got_s[$];
        bit   got_l[$];
        r            = jobs[j];
        idx          = start_idx;
        accepted     = (start_idx > 0);
        occ          = start_idx;
        full_viol    = 0;
        comp_viol    = 0;
        start_cnt    = 0;
        cyc_start    = -1;
        cyc_last_out = -1;
        mon_wait     = 0;
        mon_pending  = 0;
        in_compute   = 0;
        done         = 0;
        cyc          = 0;
        while (!done && cyc < 400) begin
            if (!s_tvalid || accepted) begin
                if (idx < r.nw && (r.gap == 0 || $urandom_range(0, 2) != 0)) begin
                    s_tvalid = 1'b1;
                    s_tdata  = DW'(idx + 1);
                    s_tlast  = (idx + 1 == r.tl);
                end else begin
                    s_tvalid = 1'b0;
                    s_tlast  = 1'b0;
                end
            end
            m_tready = (r.rdy_mode == 0) ? 1'b1 : rdy_pat(cyc);
            if (mon_pending && mon_wait <= 1) begin
                mon_tvalid = 1'b1;
                mon_tready = 1'b1;
                mon_tlast  = (mon_wait == 0);
            end else begin
                mon_tvalid = 1'b0;
                mon_tready = 1'b0;
                mon_tlast  = 1'b0;
            end
            if (mon_pending && mon_wait > 0) mon_wait--;
            @(negedge clk);
            if (occ >= 2 && s_tready) full_viol++;
            if (in_compute && s_tready) comp_viol++;
            accepted = s_tvalid && s_tready;
            if (m_tvalid && m_tready) begin
                got_d.push_back(int'(m_tdata));
                got_s.push_back(sel);
                got_l.push_back(m_tlast);
                cyc_last_out = cyc;
                occ--;
            end
            if (accepted) begin
                if (idx < 2 * SIZE) occ++;
                idx++;
            end
            if (start) begin
                start_cnt++;
                if (cyc_start < 0) cyc_start = cyc;
                mon_pending = 1;
                in_compute  = 1;
                mon_wait    = 2;
            end
            if (mon_tvalid && mon_tready && mon_tlast) begin
                mon_pending = 0;
                in_compute  = 0;
            end
            if (idx >= r.nw && !mon_pending && !busy) done = 1;
            @(posedge clk);
            #1;
            cyc++;
        end
        s_tvalid   = 1'b0;
        s_tlast    = 1'b0;
        mon_tvalid = 1'b0;
        mon_tready = 1'b0;
        mon_tlast  = 1'b0;
        check($sformatf("job%0d_done", j), done, 1);
        check($sformatf("job%0d_fwd_count", j), got_d.size(), r.exp_fwd);
        bad_seq = 0;
        n = (got_d.size() < r.exp_fwd) ? got_d.size() : r.exp_fwd;
        for (int k = 0; k < n; k++) begin
            if (got_d[k] != k + 1) bad_seq++;
            if (got_s[k] != (k >= SIZE)) bad_seq++;
            if (got_l[k] != ((k == SIZE - 1) || (k == 2 * SIZE - 1) || (k == r.tl - 1))) bad_seq++;
        end
        check($sformatf("job%0d_word_seq_errors", j), bad_seq, 0);
        check($sformatf("job%0d_start_cycles", j), start_cnt, r.exp_start);
        if (r.exp_start > 0)
            check($sformatf("job%0d_start_cycle", j), cyc_start, cyc_last_out + 1);
        check($sformatf("job%0d_ready_when_full", j), full_viol, 0);
        check($sformatf("job%0d_ready_in_compute", j), comp_viol, 0);
        check($sformatf("job%0d_job_count", j), job_count, r.exp_jc);
        check($sformatf("job%0d_err_len", j), err_len, r.exp_err);
        check($sformatf("job%0d_busy", j), busy, 0);
    endtask

    initial begin
        int viol, idx;
        jobs[0] = '{8, 8, 0, 0, 8, 1, 1, 0};    // clean job, sink always ready
        jobs[1] = '{8, 8, 1, 1, 8, 1, 2, 0};    // sink backpressure + source gaps
        jobs[2] = '{3, 3, 0, 0, 3, 0, 2, 1};    // early tlast on word 3
        jobs[3] = '{8, 8, 0, 0, 8, 1, 3, 1};    // recovery job, error still sticky
        jobs[4] = '{10, 10, 1, 0, 8, 1, 4, 1};  // missing tlast, words 9-10 drained
        jobs[5] = '{8, 8, 0, 0, 8, 1, 5, 0};    // after enable gating
        jobs[6] = '{8, 8, 0, 1, 8, 1, 1, 0};    // after mid-job reset

        rst_n      = 1'b0;
        s_tdata    = '0;
        s_tvalid   = 1'b0;
        s_tlast    = 1'b0;
        m_tready   = 1'b1;
        mon_tvalid = 1'b0;
        mon_tready = 1'b0;
        mon_tlast  = 1'b0;
        enable     = 1'b1;
        err_clr    = 1'b0;
        #1;
        check("reset_ctrl_outputs", {s_tready, m_tvalid, m_tlast, sel, start, busy, err_len}, 0);
        check("reset_data_outputs", {m_tdata, job_count}, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int j = 0; j < 5; j++) run_job(j, 0);

        // Sticky error clears with a one-cycle err_clr pulse.
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        check("err_clr_clears", err_len, 0);

        // enable = 0 blocks a new job even with data waiting.
        enable = 1'b0;
        @(posedge clk);
        #1;
        s_tvalid = 1'b1;
        s_tdata  = 32'd1;
        s_tlast  = 1'b0;
        viol = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (s_tready) viol++;
            @(posedge clk);
            #1;
        end
        check("enable0_blocks_ready", viol, 0);
        enable = 1'b1;
        @(negedge clk);
        check("enable1_ready_same_cycle", s_tready, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("enable1_ready_next_cycle", s_tready, 1);
        @(posedge clk);
        #1;
        run_job(5, 1);

        // Reset after the fifth word drops the job without a start.
        idx = 0;
        m_tready = 1'b1;
        for (int c = 0; c < 50 && idx < 5; c++) begin
            s_tvalid = 1'b1;
            s_tdata  = DW'(idx + 1);
            s_tlast  = 1'b0;
            @(negedge clk);
            if (s_tvalid && s_tready) idx++;
            @(posedge clk);
            #1;
        end
        check("midjob_words_accepted", idx, 5);
        rst_n    = 1'b0;
        s_tvalid = 1'b0;
        #1;
        check("midjob_reset_ctrl_outputs", {s_tready, m_tvalid, m_tlast, sel, start, busy, err_len}, 0);
        check("midjob_reset_data_outputs", {m_tdata, job_count}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        viol = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (start || busy || m_tvalid) viol++;
            @(posedge clk);
            #1;
        end
        check("post_reset_quiet", viol, 0);
        run_job(6, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
